// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the CPU's single memory bus port between instruction fetch (IF) and
// data access (MEM). Data has fixed priority over fetch. Each access is
// registered onto the bus, waits for bus_ack or a timeout, and then returns a
// one-cycle ready pulse to its owner. A fetch that sees a pipeline flush at
// any point from grant to completion is dropped silently, so a stale
// instruction never reaches the IF stage.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; arbitrate dm_req over if_req
// FETCH | fetch on the bus, waiting for bus_ack or timeout
// DATA  | data access on the bus, waiting for bus_ack or timeout
// RESP  | one-cycle response slot; ready/err pulses are visible here

module mem_port_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd255,
    parameter int          AW      = 32,
    parameter int          DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [3:0]    dm_sel,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    input  logic          flush,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [3:0]    bus_sel,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          bus_err,
    output logic          stall_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic          owner_dm;   // 1 = data requester owns the access, 0 = fetch
    logic          kill;       // fetch in flight was overtaken by a flush
    logic [15:0]   count;      // cycles spent waiting for bus_ack

    logic          waiting;
    logic          done_ack;
    logic          done_timeout;
    logic          done_any;
    logic          kill_now;
    logic [DW-1:0] resp_data;

    // Completion decode for the access currently on the bus. An ack in the
    // last allowed cycle still wins over the timeout.
    always_comb begin
        waiting      = 1'b0;
        done_ack     = 1'b0;
        done_timeout = 1'b0;
        done_any     = 1'b0;
        kill_now     = 1'b0;
        resp_data    = '0;
        waiting      = (state == FETCH) || (state == DATA);
        done_ack     = waiting && bus_ack;
        done_timeout = waiting && !bus_ack && (count == (TIMEOUT - 16'd1));
        done_any     = done_ack || done_timeout;
        // A flush in the completion cycle itself must also suppress delivery.
        kill_now     = kill || (!owner_dm && flush);
        resp_data    = done_ack ? bus_rdata : '0;
    end

    // Arbitration, bus registers, timeout counter and response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            kill      <= 1'b0;
            count     <= 16'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= 4'b0000;
            bus_err   <= 1'b0;
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_ready  <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            bus_err  <= 1'b0;

            case (state)
                IDLE: begin
                    count <= 16'd0;
                    if (dm_req) begin
                        bus_req   <= 1'b1;
                        bus_we    <= dm_we;
                        bus_addr  <= dm_addr;
                        bus_wdata <= dm_wdata;
                        bus_sel   <= dm_sel;
                        owner_dm  <= 1'b1;
                        kill      <= 1'b0;
                        state     <= DATA;
                    end else if (if_req) begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= if_addr;
                        bus_sel  <= 4'b1111;
                        owner_dm <= 1'b0;
                        kill     <= flush;
                        state    <= FETCH;
                    end
                end

                FETCH, DATA: begin
                    if (!owner_dm && flush) begin
                        kill <= 1'b1;
                    end
                    if (done_any) begin
                        bus_req <= 1'b0;
                        bus_err <= done_timeout;
                        count   <= 16'd0;
                        state   <= RESP;
                        if (owner_dm) begin
                            dm_ready <= 1'b1;
                            if (!bus_we) begin
                                dm_rdata <= resp_data;
                            end
                        end else if (!kill_now) begin
                            if_ready <= 1'b1;
                            if_rdata <= resp_data;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                RESP: begin
                    kill  <= 1'b0;
                    count <= 16'd0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pipeline stall: any requester still waiting for its ready pulse.
    always_comb begin
        stall_req = 1'b0;
        stall_req = (if_req && !if_ready) || (dm_req && !dm_ready);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory bus port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Registers the bus transaction and returns a one-cycle ready pulse to the owning requester.
- Drives a stall request to pipeline control while any access is pending.
- Suppresses delivery of a fetch that was in flight when the pipeline is redirected by an exception or jump (flush).

Parameters:
- TIMEOUT, 16'd255: max cycles a granted access waits for bus_ack before it is forcibly completed with an error.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high (1'b1 = reset).
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  AW  fetch address (the PC).
- if_rdata  out  DW  fetched instruction; valid when if_ready=1.
- if_ready  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_sel  in  4  byte lane enables.
- dm_rdata  out  DW  read data; valid when dm_ready=1.
- dm_ready  out  1  one-cycle data completion pulse.
- flush  in  1  pipeline redirect (exception or taken jump) this cycle.
- bus_req  out  1  bus transaction request (registered).
- bus_we  out  1  bus write enable.
- bus_addr  out  AW  bus address.
- bus_wdata  out  DW  bus write data.
- bus_sel  out  4  bus byte enables; 4'b1111 for fetches.
- bus_rdata  in  DW  bus read data; sampled when bus_ack=1.
- bus_ack  in  1  transaction complete, same cycle or later than bus_req.
- bus_err  out  1  one-cycle pulse in RESP when the access timed out.
- stall_req  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).

Behaviour:
- States: IDLE, FETCH, DATA, RESP. A one-bit owner flag (IF/DM) records who holds the current access.
- Reset (rst=1 at an edge):
  - state=IDLE; bus_req, bus_we, bus_wdata, bus_addr, bus_sel, if_ready, dm_ready, bus_err all 0; if_rdata and dm_rdata 0; kill=0; timeout counter=0.
  - Reset mid-transaction drops bus_req on the next cycle and never produces a ready pulse.
- IDLE:
  - Fixed priority, data over fetch.
  - dm_req=1: latch dm_addr, dm_we, dm_wdata, dm_sel onto the bus registers; bus_req<=1; owner=DM; go to DATA.
  - Else if_req=1: latch if_addr; bus_we<=0; bus_sel<=4'b1111; bus_req<=1; owner=IF; go to FETCH. kill<=flush in this cycle.
- FETCH / DATA:
  - bus_req and bus fields stay constant; counter increments each cycle.
  - On bus_ack=1: capture bus_rdata; bus_req<=0; go to RESP.
  - If counter reaches TIMEOUT-1 without ack: bus_req<=0; captured data=0; err flag set; go to RESP.
  - In FETCH, flush=1 in any cycle (including the ack cycle) sets kill.
- RESP (exactly one cycle, no new grant):
  - owner=IF and kill=0: if_ready=1, if_rdata=captured data.
  - owner=IF and kill=1: no if_ready pulse; if_rdata keeps its old value.
  - owner=DM: dm_ready=1. dm_rdata=captured data on reads and is unchanged on writes. Data accesses are never killed.
  - bus_err=1 if the err flag is set.
  - Clear kill, counter and err; go to IDLE.
- Latency: request sampled in IDLE at edge N; bus_req high from N+1; ack at cycle N+1+k gives a ready pulse at N+2+k. Minimum 2 cycles; peak throughput one access per 3 cycles.
- Requesters keep req/address stable until ready. A request still held during the ready cycle is treated as a new request in the following IDLE.
- A killed fetch returns to IDLE. IF re-requests with the redirected PC; the stale instruction never reaches IF.
- Simultaneous dm_req and if_req in IDLE: DATA is granted, and FETCH is granted in the IDLE after its RESP.
- flush while owner=DM: no effect on the data access.

Test Plan:
- Fetch only, memory acks same cycle: if_req=1, if_addr=0x00000004, bus_rdata=0x8C010000 → bus_req high 1 cycle with bus_addr=0x4 and bus_sel=4'hF; if_ready pulse 2 cycles after request with if_rdata=0x8C010000; stall_req=1 until then.
- Both requests in the same IDLE cycle: dm_req (write 0x12345678 to 0x100, sel=4'b0011) and if_req (0x8) → data granted first with bus_we=1; dm_ready pulses, dm_rdata unchanged; then fetch of 0x8 is issued.
- Flush during fetch: bus_ack delayed 3 cycles, flush pulses in wait cycle 2 → no if_ready pulse, if_rdata unchanged, next if_req with the new PC (0x00000380) is served normally.
- Timeout with TIMEOUT=4 and bus_ack held low: bus_req drops after 4 cycles; RESP gives dm_ready=1, bus_err=1, dm_rdata=0.
- Reset mid-access: rst=1 while in DATA → next cycle bus_req=0, no dm_ready pulse; after rst=0 a new fetch completes with 2-cycle minimum latency.
